spm_seq_ctrl: RTL

- Sequencer that drives one `spm` serial-parallel multiplier instance.
- Accepts a parallel operand pair (x, y) over a valid/ready request channel.
- Clears the spm, then feeds y serially LSB-first for 2*SIZE cycles while holding x static. It deserialises the spm serial product output into a 2*SIZE-bit result and returns it over a valid/ready response channel.
- Sits between a bus-side requester and the spm macro, one controller per spm instance.

---
 rtl/spm_seq_pkg.sv | 24 ++
 rtl/spm_seq_deser.sv | 43 ++++
 rtl/spm_seq_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spm_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : spm_seq_pkg
// Brief    : Shared state encoding and shift-length helper for spm_seq_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The extra PIPE_DLY cycles drain the spm pipeline after the last y bit.
  function automatic int shift_len(input int size, input int pipe_dly);
    return 2 * size + pipe_dly;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spm_seq_deser.sv
//------------------------------------------------------------------------------
// Module   : spm_seq_deser
// Brief    : Shift-in register (MSB entry, LSB-first arrival) with enable/clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spm_seq_deser #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      shift_d = {din, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule

`default_nettype wire

// File: rtl/spm_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : spm_seq_ctrl
// Brief    : Sequencer feeding one spm serial-parallel multiplier; serialises y,
//            deserialises the product. Define SPM_SEQ_CTRL_SIGNED_EN for
//            sign-extended (two's-complement) operation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spm_seq_ctrl
  import spm_seq_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int PIPE_DLY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SIZE-1:0]   req_x,
  input  logic [SIZE-1:0]   req_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*SIZE-1:0] res_p,
  output logic              busy,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
);

  localparam int N     = shift_len(SIZE, PIPE_DLY);
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(SIZE);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_SIZE  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_2SIZE = CNT_W'(2 * SIZE);
  localparam logic [CNT_W-1:0] CNT_DLY   = CNT_W'(PIPE_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   x_q, x_d;
  logic [SIZE-1:0]   ybuf_q, ybuf_d;
  logic              prod_clr;
  logic              prod_en;
  logic              ext_bit;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  assign ext_bit = ybuf_q[SIZE-1];
`else
  assign ext_bit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    ybuf_d    = ybuf_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    spm_rst   = 1'b0;
    spm_y     = 1'b0;
    prod_clr  = 1'b0;
    prod_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        spm_rst   = 1'b1;
        if (req_valid) begin
          x_d      = req_x;
          ybuf_d   = req_y;
          prod_clr = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        spm_rst = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q < CNT_SIZE) begin
          spm_y = ybuf_q[cnt_q[IDX_W-1:0]];
        end else if (cnt_q < CNT_2SIZE) begin
          spm_y = ext_bit;
        end
        // Product bit i appears PIPE_DLY cycles after y bit i was driven.
        prod_en = (cnt_q >= CNT_DLY);
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      ybuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      ybuf_q  <= ybuf_d;
    end
  end

  spm_seq_deser #(
    .WIDTH (2 * SIZE)
  ) u_prod (
    .clk (clk),
    .rst (rst),
    .clr (prod_clr),
    .en  (prod_en),
    .din (spm_p),
    .q   (res_p)
  );

  assign busy  = (state_q != IDLE);
  assign spm_x = x_q;

endmodule

`default_nettype wire
